dmem_watch_monitor: RTL and testbench

DMEM_WATCH_MONITOR -- requirements
Module: dmem_watch_monitor

---
 rtl/rv_mon_pkg.sv | 16 +
 rtl/mon_watch_ch.sv | 58 +++++
 rtl/dmem_watch_monitor.sv | 140 ++++++++++++++
 tb/tb_dmem_watch_monitor.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mon_pkg.sv
// rv_mon_pkg: shared types and constants for the DMEM watch monitor
package rv_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    localparam logic [31:0] DONE_ADDR_DEF = 32'h00002000;
    localparam logic [31:0] PASS_VAL_DEF  = 32'hDEADBEEF;
    localparam int          CH_IDX_W      = 3;

endpackage

// File: rtl/mon_watch_ch.sv
// mon_watch_ch: one address-watch channel with config, saturating hit counter and last-data capture
module mon_watch_ch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              snoop,
    input  logic              dmem_we,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_din,
    input  logic              cfg_wr,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [ADDR_W-1:0] cfg_mask,
    input  logic              cfg_en,
    input  logic              wipe,
    output logic              hit,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] last
);

    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] mask_r;
    logic              en_r;
    logic              match;

    // match against the config held before any same-cycle write
    assign match = snoop && en_r && dmem_we && (((dmem_addr ^ addr_r) & mask_r) == '0);

    // config write beats a statistics wipe, which beats a match update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r <= '0;
            mask_r <= '0;
            en_r   <= 1'b0;
            hit    <= 1'b0;
            count  <= '0;
            last   <= '0;
        end else if (cfg_wr) begin
            addr_r <= cfg_addr;
            mask_r <= cfg_mask;
            en_r   <= cfg_en;
            hit    <= 1'b0;
            count  <= '0;
            last   <= '0;
        end else if (wipe) begin
            hit    <= 1'b0;
            count  <= '0;
            last   <= '0;
        end else if (match) begin
            hit    <= 1'b1;
            count  <= (count == '1) ? count : count + 1'b1;
            last   <= dmem_din;
        end
    end

endmodule

// File: rtl/dmem_watch_monitor.sv
// dmem_watch_monitor: snoops DMEM stores for a completion mailbox, a watchdog and address-watch channels
module dmem_watch_monitor
    import rv_mon_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_CH    = 4,
    parameter int                CNT_W     = 16,
    parameter logic [ADDR_W-1:0] DONE_ADDR = ADDR_W'(DONE_ADDR_DEF),
    parameter logic [DATA_W-1:0] PASS_VAL  = DATA_W'(PASS_VAL_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                clear,
    input  logic [31:0]         timeout_lim,
    input  logic [ADDR_W-1:0]   dmem_addr,
    input  logic                dmem_we,
    input  logic [DATA_W-1:0]   dmem_din,
    input  logic                cfg_we,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [ADDR_W-1:0]   cfg_mask,
    input  logic                cfg_en,
    output logic                done_flag,
    output logic                pass,
    output logic                fail,
    output logic                timeout,
    output logic                halt_req,
    output logic [DATA_W-1:0]   fail_code,
    output logic [31:0]         cycle_count,
    output logic [NUM_CH-1:0]   ch_hit,
    output logic [CNT_W-1:0]    rd_count,
    output logic [DATA_W-1:0]   rd_last
);

    state_t            state;
    state_t            state_nx;
    logic              run;
    logic              go;
    logic              mbox;
    logic              expire;
    logic [CNT_W-1:0]  cnt_a  [NUM_CH];
    logic [DATA_W-1:0] last_a [NUM_CH];

    // clear outranks everything, so it suppresses both snooping and arming
    assign run    = (state == ST_RUN) && !clear;
    assign go     = (state == ST_IDLE) && start && !clear;
    assign mbox   = dmem_we && (dmem_addr == DONE_ADDR);
    assign expire = (timeout_lim != '0) && (cycle_count == timeout_lim - 32'd1);

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    // next state: clear, then arm, then mailbox store ahead of watchdog expiry
    always_comb begin
        state_nx = state;
        if (clear)
            state_nx = ST_IDLE;
        else if (state == ST_IDLE && start)
            state_nx = ST_RUN;
        else if (state == ST_RUN && mbox)
            state_nx = (dmem_din == PASS_VAL) ? ST_PASS : ST_FAIL;
        else if (state == ST_RUN && expire)
            state_nx = ST_TIMEOUT;
    end

    // terminal flags registered from the next state so they rise one cycle after the event
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_flag <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            done_flag <= state_nx inside {ST_PASS, ST_FAIL, ST_TIMEOUT};
            pass      <= state_nx == ST_PASS;
            fail      <= state_nx == ST_FAIL;
            timeout   <= state_nx == ST_TIMEOUT;
        end
    end

    assign halt_req = done_flag;

    // failing mailbox data capture and saturating RUN-cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail_code   <= '0;
            cycle_count <= '0;
        end else begin
            if (clear || go)
                fail_code <= '0;
            else if (run && state_nx == ST_FAIL)
                fail_code <= dmem_din;
            if (go)
                cycle_count <= '0;
            else if (run && cycle_count != '1)
                cycle_count <= cycle_count + 32'd1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        mon_watch_ch #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .snoop     (run),
            .dmem_we   (dmem_we),
            .dmem_addr (dmem_addr),
            .dmem_din  (dmem_din),
            .cfg_wr    (cfg_we && cfg_ch == CH_IDX_W'(k)),
            .cfg_addr  (cfg_addr),
            .cfg_mask  (cfg_mask),
            .cfg_en    (cfg_en),
            .wipe      (go),
            .hit       (ch_hit[k]),
            .count     (cnt_a[k]),
            .last      (last_a[k])
        );
    end

    // readback of the selected channel; out-of-range indices read zero
    always_comb begin
        rd_count = '0;
        rd_last  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_IDX_W'(i)) begin
                rd_count = cnt_a[i];
                rd_last  = last_a[i];
            end
        end
    end

endmodule

// File: tb/tb_dmem_watch_monitor.sv
// tb_dmem_watch_monitor: directed scenarios plus a randomized run against a behavioural model
module tb_dmem_watch_monitor;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PASS = 2;
    localparam int M_FAIL = 3;
    localparam int M_TO   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] timeout_lim = '0;
    logic [31:0] dmem_addr = '0;
    logic        dmem_we = 1'b0;
    logic [31:0] dmem_din = '0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_ch = '0;
    logic [31:0] cfg_addr = '0;
    logic [31:0] cfg_mask = '0;
    logic        cfg_en = 1'b0;

    logic        done_flag, pass, fail, timeout, halt_req;
    logic [31:0] fail_code, cycle_count, rd_last;
    logic [3:0]  ch_hit;
    logic [15:0] rd_count;

    logic        b_done_flag, b_pass, b_fail, b_timeout, b_halt_req;
    logic [31:0] b_fail_code, b_cycle_count, b_rd_last;
    logic [1:0]  b_ch_hit;
    logic [1:0]  b_rd_count;

    int total = 0;
    int bad = 0;

    dmem_watch_monitor dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .timeout_lim(timeout_lim),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_din(dmem_din),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_en(cfg_en),
        .done_flag(done_flag), .pass(pass), .fail(fail), .timeout(timeout), .halt_req(halt_req),
        .fail_code(fail_code), .cycle_count(cycle_count), .ch_hit(ch_hit),
        .rd_count(rd_count), .rd_last(rd_last)
    );

    // narrow-counter instance sharing the same stimulus
    dmem_watch_monitor #(.NUM_CH(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .timeout_lim(timeout_lim),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_din(dmem_din),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_en(cfg_en),
        .done_flag(b_done_flag), .pass(b_pass), .fail(b_fail), .timeout(b_timeout), .halt_req(b_halt_req),
        .fail_code(b_fail_code), .cycle_count(b_cycle_count), .ch_hit(b_ch_hit),
        .rd_count(b_rd_count), .rd_last(b_rd_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start = 1'b0;
        clear = 1'b0;
        dmem_we = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        dmem_we = 1'b1;
        dmem_addr = a;
        dmem_din = d;
        tick();
        dmem_we = 1'b0;
    endtask

    task automatic cfg(input logic [2:0] ch, input logic [31:0] a, input logic [31:0] m, input logic e);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_addr = a;
        cfg_mask = m;
        cfg_en = e;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b1;
        #3;
        total++;
        if ({done_flag, pass, fail, timeout, halt_req, fail_code, cycle_count, ch_hit, rd_count, rd_last} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got flags=%b fc=%h cc=%h hit=%b cnt=%h last=%h want all 0",
                     {done_flag, pass, fail, timeout, halt_req}, fail_code, cycle_count, ch_hit, rd_count, rd_last);
        end
        tick();
        total++;
        if ({done_flag, cycle_count} !== '0) begin
            bad++;
            $display("FAIL reset_hold got done=%b cc=%0d want 0 0", done_flag, cycle_count);
        end
        start = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_pass();
        do_start();
        store(32'h2000, 32'hDEADBEEF);
        total++;
        if ({done_flag, pass, fail, timeout, halt_req} !== 5'b11001 || fail_code !== 32'h0) begin
            bad++;
            $display("FAIL pass_flags got %b fc=%h want 11001 fc=0", {done_flag, pass, fail, timeout, halt_req}, fail_code);
        end
        total++;
        if (cycle_count !== 32'd1) begin
            bad++;
            $display("FAIL pass_cycles got %0d want 1", cycle_count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        total++;
        if ({done_flag, pass} !== 2'b11 || cycle_count !== 32'd1) begin
            bad++;
            $display("FAIL pass_hold got done=%b pass=%b cc=%0d want 1 1 1", done_flag, pass, cycle_count);
        end
        do_clear();
        total++;
        if ({done_flag, pass, fail, timeout, halt_req} !== 5'b00000) begin
            bad++;
            $display("FAIL pass_clear got %b want 00000", {done_flag, pass, fail, timeout, halt_req});
        end
    endtask

    task automatic test_fail();
        do_start();
        store(32'h2000, 32'h0000002A);
        total++;
        if ({done_flag, pass, fail, timeout, halt_req} !== 5'b10101 || fail_code !== 32'h2A) begin
            bad++;
            $display("FAIL fail_flags got %b fc=%h want 10101 fc=2a", {done_flag, pass, fail, timeout, halt_req}, fail_code);
        end
        store(32'h2000, 32'hDEADBEEF);
        total++;
        if ({pass, fail} !== 2'b01 || fail_code !== 32'h2A) begin
            bad++;
            $display("FAIL fail_ignore got pass=%b fail=%b fc=%h want 0 1 2a", pass, fail, fail_code);
        end
        do_clear();
        total++;
        if ({done_flag, pass, fail, timeout, halt_req} !== 5'b00000 || fail_code !== 32'h0) begin
            bad++;
            $display("FAIL fail_clear got %b fc=%h want 00000 fc=0", {done_flag, pass, fail, timeout, halt_req}, fail_code);
        end
    endtask

    task automatic test_timeout();
        timeout_lim = 32'd10;
        do_start();
        repeat (9) tick();
        total++;
        if (timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early got %b want 0", timeout);
        end
        tick();
        total++;
        if ({done_flag, pass, fail, timeout, halt_req} !== 5'b10011 || cycle_count !== 32'd10) begin
            bad++;
            $display("FAIL timeout_fire got %b cc=%0d want 10011 cc=10", {done_flag, pass, fail, timeout, halt_req}, cycle_count);
        end
        do_clear();
        do_start();
        repeat (9) tick();
        store(32'h2000, 32'hDEADBEEF);
        total++;
        if ({pass, timeout} !== 2'b10) begin
            bad++;
            $display("FAIL timeout_vs_mbox got pass=%b to=%b want 1 0", pass, timeout);
        end
        do_clear();
        timeout_lim = 32'd0;
        do_start();
        repeat (20) tick();
        total++;
        if (done_flag !== 1'b0 || cycle_count !== 32'd20) begin
            bad++;
            $display("FAIL timeout_disabled got done=%b cc=%0d want 0 20", done_flag, cycle_count);
        end
        do_clear();
    endtask

    task automatic test_watch();
        cfg(3'd0, 32'h1000, 32'hFFFFF000, 1'b1);
        do_start();
        store(32'h1004, 32'h11111111);
        store(32'h1FFC, 32'h22222222);
        store(32'h2004, 32'h33333333);
        total++;
        if (ch_hit !== 4'b0001 || rd_count !== 16'd2 || rd_last !== 32'h22222222) begin
            bad++;
            $display("FAIL watch_hits got hit=%b cnt=%0d last=%h want 0001 2 22222222", ch_hit, rd_count, rd_last);
        end
        cfg(3'd4, 32'h0, 32'h0, 1'b1);
        total++;
        if (rd_count !== 16'd0 || rd_last !== 32'h0) begin
            bad++;
            $display("FAIL watch_oor_read got cnt=%0d last=%h want 0 0", rd_count, rd_last);
        end
        cfg_ch = 3'd0;
        #1;
        total++;
        if (rd_count !== 16'd2 || ch_hit !== 4'b0001) begin
            bad++;
            $display("FAIL watch_oor_write got cnt=%0d hit=%b want 2 0001", rd_count, ch_hit);
        end
        do_clear();
        total++;
        if (rd_count !== 16'd2 || ch_hit[0] !== 1'b1) begin
            bad++;
            $display("FAIL watch_clear_keep got cnt=%0d hit=%b want 2 1", rd_count, ch_hit[0]);
        end
        do_start();
        total++;
        if (rd_count !== 16'd0 || ch_hit !== 4'b0000 || rd_last !== 32'h0) begin
            bad++;
            $display("FAIL watch_start_wipe got cnt=%0d hit=%b last=%h want 0 0000 0", rd_count, ch_hit, rd_last);
        end
        store(32'h1008, 32'h44);
        total++;
        if (rd_count !== 16'd1 || rd_last !== 32'h44) begin
            bad++;
            $display("FAIL watch_cfg_kept got cnt=%0d last=%h want 1 44", rd_count, rd_last);
        end
        do_clear();
    endtask

    task automatic test_sat();
        cfg(3'd0, 32'h3000, 32'hFFFFFFFF, 1'b1);
        do_start();
        repeat (5) store(32'h3000, $urandom);
        total++;
        if (b_rd_count !== 2'd3 || rd_count !== 16'd5) begin
            bad++;
            $display("FAIL sat_count got narrow=%0d wide=%0d want 3 5", b_rd_count, rd_count);
        end
        cfg_we = 1'b1;
        dmem_we = 1'b1;
        dmem_addr = 32'h3000;
        tick();
        quiet();
        total++;
        if (b_rd_count !== 2'd0 || rd_count !== 16'd0 || ch_hit[0] !== 1'b0 || b_ch_hit[0] !== 1'b0) begin
            bad++;
            $display("FAIL sat_cfg_vs_match got narrow=%0d wide=%0d hit=%b/%b want 0 0 0/0",
                     b_rd_count, rd_count, ch_hit[0], b_ch_hit[0]);
        end
        do_clear();
    endtask

    task automatic test_reset_mid();
        do_start();
        store(32'h3000, 32'h55);
        total++;
        if (rd_count !== 16'd1 || cycle_count !== 32'd1) begin
            bad++;
            $display("FAIL rstmid_pre got cnt=%0d cc=%0d want 1 1", rd_count, cycle_count);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({done_flag, pass, fail, timeout, halt_req, fail_code, cycle_count, ch_hit, rd_count, rd_last} !== '0) begin
            bad++;
            $display("FAIL rstmid_async got cc=%0d hit=%b cnt=%0d last=%h want all 0", cycle_count, ch_hit, rd_count, rd_last);
        end
        tick();
        rst = 1'b1;
        cfg(3'd0, 32'h2000, 32'hFFFFFFFF, 1'b1);
        store(32'h2000, 32'hDEADBEEF);
        total++;
        if ({done_flag, pass} !== 2'b00 || ch_hit !== 4'b0000 || cycle_count !== 32'd0) begin
            bad++;
            $display("FAIL rstmid_ignore got done=%b pass=%b hit=%b cc=%0d want 0 0 0000 0", done_flag, pass, ch_hit, cycle_count);
        end
        do_start();
        store(32'h2000, 32'hDEADBEEF);
        total++;
        if (pass !== 1'b1 || ch_hit !== 4'b0001 || rd_count !== 16'd1) begin
            bad++;
            $display("FAIL rstmid_rearm got pass=%b hit=%b cnt=%0d want 1 0001 1", pass, ch_hit, rd_count);
        end
        do_clear();
    endtask

    task automatic test_random();
        logic [31:0] apool [5] = '{32'h1000, 32'h1004, 32'h1100, 32'h3000, 32'h1FFC};
        logic [31:0] mpool [5] = '{32'hFFFFFFFF, 32'hFFFFF000, 32'hFFFFFF00, 32'h0, 32'hFFFFFFF0};
        logic [31:0] lpool [3] = '{32'd0, 32'd8, 32'd25};
        int          ms;
        logic [31:0] m_cc, m_fc;
        logic [31:0] m_addr [4];
        logic [31:0] m_mask [4];
        logic        m_en [4];
        logic        m_hit [4];
        logic [15:0] m_cnt [4];
        logic [31:0] m_last [4];
        logic        run_a, go_a, exp_a;
        logic [3:0]  e_hit;
        logic [15:0] e_cnt;
        logic [31:0] e_last;
        quiet();
        timeout_lim = '0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        ms = M_IDLE;
        m_cc = '0;
        m_fc = '0;
        for (int k = 0; k < 4; k++) begin
            m_addr[k] = '0; m_mask[k] = '0; m_en[k] = 1'b0;
            m_hit[k] = 1'b0; m_cnt[k] = '0; m_last[k] = '0;
        end
        for (int n = 0; n < 600; n++) begin
            start = ($urandom_range(3) == 0);
            clear = ($urandom_range(14) == 0);
            dmem_we = $urandom_range(1);
            if ($urandom_range(11) == 0) begin
                dmem_addr = 32'h2000;
                dmem_din = $urandom_range(1) ? 32'hDEADBEEF : $urandom;
            end else begin
                dmem_addr = apool[$urandom_range(4)];
                dmem_din = $urandom;
            end
            cfg_we = ($urandom_range(7) == 0);
            cfg_ch = 3'($urandom_range(7));
            cfg_addr = apool[$urandom_range(4)];
            cfg_mask = mpool[$urandom_range(4)];
            cfg_en = ($urandom_range(3) != 0);
            if (ms == M_IDLE && $urandom_range(3) == 0) timeout_lim = lpool[$urandom_range(2)];
            run_a = (ms == M_RUN) && !clear;
            go_a = (ms == M_IDLE) && start && !clear;
            for (int k = 0; k < 4; k++) begin
                if (cfg_we && int'(cfg_ch) == k) begin
                    m_addr[k] = cfg_addr; m_mask[k] = cfg_mask; m_en[k] = cfg_en;
                    m_hit[k] = 1'b0; m_cnt[k] = '0; m_last[k] = '0;
                end else if (go_a) begin
                    m_hit[k] = 1'b0; m_cnt[k] = '0; m_last[k] = '0;
                end else if (run_a && m_en[k] && dmem_we && ((dmem_addr ^ m_addr[k]) & m_mask[k]) == 0) begin
                    m_hit[k] = 1'b1;
                    if (m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
                    m_last[k] = dmem_din;
                end
            end
            if (clear) begin
                ms = M_IDLE;
                m_fc = '0;
            end else if (ms == M_IDLE) begin
                if (start) begin
                    ms = M_RUN;
                    m_cc = '0;
                    m_fc = '0;
                end
            end else if (ms == M_RUN) begin
                exp_a = (timeout_lim != 0) && (m_cc == timeout_lim - 1);
                if (m_cc != 32'hFFFFFFFF) m_cc = m_cc + 1;
                if (dmem_we && dmem_addr == 32'h2000) begin
                    if (dmem_din == 32'hDEADBEEF) ms = M_PASS;
                    else begin
                        ms = M_FAIL;
                        m_fc = dmem_din;
                    end
                end else if (exp_a) ms = M_TO;
            end
            tick();
            e_hit = {m_hit[3], m_hit[2], m_hit[1], m_hit[0]};
            e_cnt = (cfg_ch < 4) ? m_cnt[cfg_ch[1:0]] : 16'd0;
            e_last = (cfg_ch < 4) ? m_last[cfg_ch[1:0]] : 32'd0;
            total++;
            if ({done_flag, pass, fail, timeout, halt_req} !== {ms >= M_PASS, ms == M_PASS, ms == M_FAIL, ms == M_TO, ms >= M_PASS}) begin
                bad++;
                $display("FAIL rand_flags step=%0d got %b want model state %0d", n, {done_flag, pass, fail, timeout, halt_req}, ms);
            end
            total++;
            if (fail_code !== m_fc) begin
                bad++;
                $display("FAIL rand_fail_code step=%0d got %h want %h", n, fail_code, m_fc);
            end
            total++;
            if (cycle_count !== m_cc) begin
                bad++;
                $display("FAIL rand_cycles step=%0d got %0d want %0d", n, cycle_count, m_cc);
            end
            total++;
            if (ch_hit !== e_hit) begin
                bad++;
                $display("FAIL rand_hit step=%0d got %b want %b", n, ch_hit, e_hit);
            end
            total++;
            if (rd_count !== e_cnt || rd_last !== e_last) begin
                bad++;
                $display("FAIL rand_readback step=%0d ch=%0d got %0d/%h want %0d/%h", n, cfg_ch, rd_count, rd_last, e_cnt, e_last);
            end
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_watch();
        test_sat();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
